// File: rtl/usr_ram_tp.sv
// usr_ram_tp: single-clock 1R/1W RAM with per-bit write mask, clear-on-reset sequencer and pipelined reads
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   rst        synchronous active-high reset; restarts the clear sequence from address 0
//   rd_en      read request (ignored while clearing)
//   rd_addr    read address
//   rd_word    read data; holds its value while rd_valid is low
//   rd_valid   one-cycle pulse, RD_LAT cycles after the accepting edge
//   wr_en      write request (ignored while clearing)
//   wr_addr    write address
//   wr_word    write data
//   wr_mask    per-bit write enable, active-high
//   init_busy  high while the clear sequencer owns the array
//   drop       one-cycle pulse after a request was discarded during the clear
//
// Build option: define USR_RAM_TP_BYPASS_EN for write-first same-address
// collisions; without it a colliding read returns the old contents.
module usr_ram_tp #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [WORD_W-1:0] wr_mask,
    output logic              init_busy,
    output logic              drop
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_addr;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   pipe_word [RD_LAT];
    logic [RD_LAT-1:0]   pipe_vld;
    logic                rd_ok;
    logic                wr_ok;
    logic [WORD_W-1:0]   rd_data;

    assign rd_ok = (state == READY) && rd_en;
    assign wr_ok = (state == READY) && wr_en;

`ifdef USR_RAM_TP_BYPASS_EN
    // write-first: a colliding read sees the merged result of this edge's write
    assign rd_data = (wr_ok && wr_addr == rd_addr) ?
                     ((wr_word & wr_mask) | (mem[rd_addr] & ~wr_mask)) : mem[rd_addr];
`else
    assign rd_data = mem[rd_addr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            drop     <= 1'b0;
        end else begin
            drop <= (state == CLEAR) && (rd_en || wr_en);
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
                if (&clr_addr)
                    state <= READY;
            end
        end
    end

    // array has no reset of its own; it is zeroed by the clear sequencer
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clr_addr] <= '0;
            else if (wr_en)
                for (int i = 0; i < WORD_W; i++)
                    if (wr_mask[i])
                        mem[wr_addr][i] <= wr_word[i];
        end
    end

    // data stages only load behind a valid, so the last stage holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++)
                pipe_word[i] <= '0;
        end else begin
            pipe_vld[0] <= rd_ok;
            if (rd_ok)
                pipe_word[0] <= rd_data;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1])
                    pipe_word[i] <= pipe_word[i-1];
            end
        end
    end

    assign rd_valid  = pipe_vld[RD_LAT-1];
    assign rd_word   = pipe_word[RD_LAT-1];
    assign init_busy = (state == CLEAR);

endmodule

// File: tb/tb_usr_ram_tp.sv
// tb_usr_ram_tp: randomized scoreboard bench for usr_ram_tp against an array-based reference model
module tb_usr_ram_tp;
    localparam int ADDR_W = 4;
    localparam int WORD_W = 16;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 0;
    logic              rst = 0;
    logic              rd_en = 0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [WORD_W-1:0] rd_word;
    logic              rd_valid;
    logic              wr_en = 0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WORD_W-1:0] wr_word = '0;
    logic [WORD_W-1:0] wr_mask = '0;
    logic              init_busy;
    logic              drop;

    usr_ram_tp #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word), .wr_mask(wr_mask),
        .init_busy(init_busy), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] word;
        int                due;
    } exp_t;

    exp_t              q[$];
    logic [WORD_W-1:0] model [DEPTH];
    int                clr_left = 0;
    logic              exp_busy = 0;
    logic              exp_drop = 0;
    logic [WORD_W-1:0] last_word = '0;
    bit                armed = 0;
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // one clock of stimulus; the model advances with the same edge
    task automatic step(input logic r, input logic [ADDR_W-1:0] ra, input logic w,
                        input logic [ADDR_W-1:0] wa, input logic [WORD_W-1:0] ww,
                        input logic [WORD_W-1:0] wm, input logic rs);
        logic [WORD_W-1:0] v;
        exp_t e;
        rst = rs; rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_word = ww; wr_mask = wm;
        @(posedge clk);
        #1;
        if (rs) begin
            clr_left  = DEPTH;
            exp_drop  = 0;
            last_word = '0;
            q.delete();
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (clr_left > 0) begin
            exp_drop = r | w;
            clr_left--;
        end else begin
            exp_drop = 0;
            if (r) begin
                v = model[ra];
`ifdef USR_RAM_TP_BYPASS_EN
                if (w && wa == ra) v = (ww & wm) | (model[ra] & ~wm);
`endif
                e.word = v;
                e.due  = cyc + RD_LAT - 1;
                q.push_back(e);
            end
            if (w) model[wa] = (ww & wm) | (model[wa] & ~wm);
        end
        exp_busy = (clr_left > 0);
        rst = 0; rd_en = 0; wr_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, '0, 0);
    endtask

    task automatic rnd(input int n);
        logic [WORD_W-1:0] m;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = '1;
                default: m = WORD_W'($urandom);
            endcase
            step(1'($urandom), ADDR_W'($urandom), 1'($urandom), ADDR_W'($urandom),
                 WORD_W'($urandom), m, 0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(1, ADDR_W'(a), 0, '0, '0, '0, 0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("init_busy", {15'b0, init_busy}, {15'b0, exp_busy});
            chk("drop", {15'b0, drop}, {15'b0, exp_drop});
            if (q.size() > 0 && q[0].due < cyc) begin
                total++; bad++;
                $display("FAIL rd_missing cyc=%0d got=no_valid want=%h", cyc, q[0].word);
                void'(q.pop_front());
            end
            if (rd_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected cyc=%0d got=%h want=no_valid", cyc, rd_word);
                end else begin
                    chk("rd_latency", 16'(cyc), 16'(q[0].due));
                    chk("rd_word", rd_word, q[0].word);
                    last_word = q[0].word;
                    void'(q.pop_front());
                end
            end else begin
                chk("rd_valid_low", {15'b0, rd_valid}, 16'h0);
                chk("rd_hold", rd_word, last_word);
            end
        end
    end

    initial begin
        step(0, '0, 0, '0, '0, '0, 1);
        armed = 1;
        // requests during the clear are dropped and must leave the array zero
        for (int i = 0; i < DEPTH; i++)
            step(1'($urandom), ADDR_W'($urandom), 1'($urandom), ADDR_W'($urandom), '1, '1, 0);
        read_all();
        step(0, '0, 1, 4'd5, 16'hBEEF, 16'hFFFF, 0);
        step(1, 4'd5, 0, '0, '0, '0, 0);
        step(0, '0, 1, 4'd3, 16'h1234, 16'hFFFF, 0);
        step(0, '0, 1, 4'd3, 16'hFFFF, 16'h00F0, 0);
        step(1, 4'd3, 0, '0, '0, '0, 0);
        step(0, '0, 1, 4'd9, 16'hFFFF, 16'h0000, 0);
        step(1, 4'd9, 0, '0, '0, '0, 0);
        step(0, '0, 1, 4'd7, 16'hAAAA, 16'hFFFF, 0);
        step(1, 4'd7, 1, 4'd7, 16'h5555, 16'hFFFF, 0);
        step(1, 4'd7, 0, '0, '0, '0, 0);
        step(1, 4'd2, 1, 4'd2, 16'h0F0F, 16'h00FF, 0);
        step(1, 4'd2, 1, 4'd4, 16'h1111, 16'hFFFF, 0);
        idle(RD_LAT + 1);
        rnd(300);
        // four back-to-back reads, reset with two still in flight
        for (int i = 0; i < 4; i++) step(1, ADDR_W'(i), 0, '0, '0, '0, 0);
        step(0, '0, 0, '0, '0, '0, 1);
        step(1, 4'd1, 1, 4'd1, 16'hFFFF, 16'hFFFF, 1);
        idle(5);
        // reset mid-clear restarts the sequence from address 0
        step(0, '0, 0, '0, '0, '0, 1);
        rnd(DEPTH);
        read_all();
        rnd(300);
        idle(RD_LAT + 3);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d_pending want=0_pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
